// File: rtl/inst_encoder_pkg.sv
// ============================================================================
// inst_encoder_pkg
// Shared mnemonic codes, MIPS opcode/funct constants, exit-sequence words and
// state/format encodings for the instruction encoder.
// Rev 1.0
// ============================================================================
`default_nettype none

package inst_encoder_pkg;

    // Mnemonic codes presented on req_op; any other value is unsupported.
    localparam logic [5:0] ENC_OP_SLL     = 6'd0;
    localparam logic [5:0] ENC_OP_SRL     = 6'd1;
    localparam logic [5:0] ENC_OP_SRA     = 6'd2;
    localparam logic [5:0] ENC_OP_SLLV    = 6'd3;
    localparam logic [5:0] ENC_OP_SRLV    = 6'd4;
    localparam logic [5:0] ENC_OP_SRAV    = 6'd5;
    localparam logic [5:0] ENC_OP_JR      = 6'd6;
    localparam logic [5:0] ENC_OP_SYSCALL = 6'd7;
    localparam logic [5:0] ENC_OP_ADD     = 6'd8;
    localparam logic [5:0] ENC_OP_ADDU    = 6'd9;
    localparam logic [5:0] ENC_OP_SUB     = 6'd10;
    localparam logic [5:0] ENC_OP_SUBU    = 6'd11;
    localparam logic [5:0] ENC_OP_AND     = 6'd12;
    localparam logic [5:0] ENC_OP_OR      = 6'd13;
    localparam logic [5:0] ENC_OP_XOR     = 6'd14;
    localparam logic [5:0] ENC_OP_NOR     = 6'd15;
    localparam logic [5:0] ENC_OP_SLT     = 6'd16;
    localparam logic [5:0] ENC_OP_SLTU    = 6'd17;
    localparam logic [5:0] ENC_OP_BLTZ    = 6'd18;
    localparam logic [5:0] ENC_OP_J       = 6'd19;
    localparam logic [5:0] ENC_OP_JAL     = 6'd20;
    localparam logic [5:0] ENC_OP_BEQ     = 6'd21;
    localparam logic [5:0] ENC_OP_BNE     = 6'd22;
    localparam logic [5:0] ENC_OP_ADDI    = 6'd23;
    localparam logic [5:0] ENC_OP_ADDIU   = 6'd24;
    localparam logic [5:0] ENC_OP_SLTI    = 6'd25;
    localparam logic [5:0] ENC_OP_SLTIU   = 6'd26;
    localparam logic [5:0] ENC_OP_ANDI    = 6'd27;
    localparam logic [5:0] ENC_OP_ORI     = 6'd28;
    localparam logic [5:0] ENC_OP_XORI    = 6'd29;
    localparam logic [5:0] ENC_OP_LUI     = 6'd30;
    localparam logic [5:0] ENC_OP_LB      = 6'd31;
    localparam logic [5:0] ENC_OP_LH      = 6'd32;
    localparam logic [5:0] ENC_OP_LW      = 6'd33;
    localparam logic [5:0] ENC_OP_LBU     = 6'd34;
    localparam logic [5:0] ENC_OP_LHU     = 6'd35;
    localparam logic [5:0] ENC_OP_SB      = 6'd36;
    localparam logic [5:0] ENC_OP_SH      = 6'd37;
    localparam logic [5:0] ENC_OP_SW      = 6'd38;

    // Primary opcodes (bits 31:26), identical to the decoder's view.
    localparam logic [5:0] OPC_SPECIAL = 6'h00;
    localparam logic [5:0] OPC_REGIMM  = 6'h01;
    localparam logic [5:0] OPC_J       = 6'h02;
    localparam logic [5:0] OPC_JAL     = 6'h03;
    localparam logic [5:0] OPC_BEQ     = 6'h04;
    localparam logic [5:0] OPC_BNE     = 6'h05;
    localparam logic [5:0] OPC_ADDI    = 6'h08;
    localparam logic [5:0] OPC_ADDIU   = 6'h09;
    localparam logic [5:0] OPC_SLTI    = 6'h0A;
    localparam logic [5:0] OPC_SLTIU   = 6'h0B;
    localparam logic [5:0] OPC_ANDI    = 6'h0C;
    localparam logic [5:0] OPC_ORI     = 6'h0D;
    localparam logic [5:0] OPC_XORI    = 6'h0E;
    localparam logic [5:0] OPC_LUI     = 6'h0F;
    localparam logic [5:0] OPC_LB      = 6'h20;
    localparam logic [5:0] OPC_LH      = 6'h21;
    localparam logic [5:0] OPC_LW      = 6'h23;
    localparam logic [5:0] OPC_LBU     = 6'h24;
    localparam logic [5:0] OPC_LHU     = 6'h25;
    localparam logic [5:0] OPC_SB      = 6'h28;
    localparam logic [5:0] OPC_SH      = 6'h29;
    localparam logic [5:0] OPC_SW      = 6'h2B;

    // SPECIAL funct codes (bits 5:0).
    localparam logic [5:0] FN_SLL     = 6'h00;
    localparam logic [5:0] FN_SRL     = 6'h02;
    localparam logic [5:0] FN_SRA     = 6'h03;
    localparam logic [5:0] FN_SLLV    = 6'h04;
    localparam logic [5:0] FN_SRLV    = 6'h06;
    localparam logic [5:0] FN_SRAV    = 6'h07;
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_SYSCALL = 6'h0C;
    localparam logic [5:0] FN_ADD     = 6'h20;
    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_SUB     = 6'h22;
    localparam logic [5:0] FN_SUBU    = 6'h23;
    localparam logic [5:0] FN_AND     = 6'h24;
    localparam logic [5:0] FN_OR      = 6'h25;
    localparam logic [5:0] FN_XOR     = 6'h26;
    localparam logic [5:0] FN_NOR     = 6'h27;
    localparam logic [5:0] FN_SLT     = 6'h2A;
    localparam logic [5:0] FN_SLTU    = 6'h2B;

    // Exit sequence: addi $v0,$zero,10 ; syscall
    localparam logic [31:0] ENC_EXIT_W0 = 32'h2002000A;
    localparam logic [31:0] ENC_EXIT_W1 = 32'h0000000C;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TERM0 = 2'd1,
        S_TERM1 = 2'd2,
        S_DONE  = 2'd3
    } enc_state_e;

    // Field-layout classes; each decides which request fields survive.
    typedef enum logic [2:0] {
        FMT_R3   = 3'd0,  // rs rt rd
        FMT_SH   = 3'd1,  // rt rd shamt (constant shifts)
        FMT_JR   = 3'd2,  // rs only
        FMT_SYS  = 3'd3,  // funct only
        FMT_I    = 3'd4,  // rs rt imm
        FMT_LUI  = 3'd5,  // rt imm
        FMT_BLTZ = 3'd6,  // rs imm, rt forced to 0
        FMT_J    = 3'd7   // 26-bit target
    } enc_fmt_e;

endpackage

`default_nettype wire

// File: rtl/inst_encoder_field_packer.sv
// ============================================================================
// inst_field_packer
// Combinational packer: mnemonic code plus fields -> 32-bit MIPS word and a
// supported flag. Fields unused by the op are forced to zero.
// Rev 1.0
// ============================================================================
`default_nettype none

module inst_field_packer
    import inst_encoder_pkg::*;
(
    input  logic [5:0]  op_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  shamt_i,
    input  logic [15:0] imm_i,
    input  logic [25:0] target_i,
    output logic [31:0] word_o,
    output logic        supported_o
);

    logic [5:0] w_opc;
    logic [5:0] w_fn;
    enc_fmt_e   w_fmt;

    // Classify the mnemonic: primary opcode, funct and field layout.
    always_comb begin
        w_opc       = OPC_SPECIAL;
        w_fn        = 6'h00;
        w_fmt       = FMT_SYS;
        supported_o = 1'b1;
        case (op_i)
            ENC_OP_SLL:     begin w_fmt = FMT_SH; w_fn = FN_SLL;  end
            ENC_OP_SRL:     begin w_fmt = FMT_SH; w_fn = FN_SRL;  end
            ENC_OP_SRA:     begin w_fmt = FMT_SH; w_fn = FN_SRA;  end
            ENC_OP_SLLV:    begin w_fmt = FMT_R3; w_fn = FN_SLLV; end
            ENC_OP_SRLV:    begin w_fmt = FMT_R3; w_fn = FN_SRLV; end
            ENC_OP_SRAV:    begin w_fmt = FMT_R3; w_fn = FN_SRAV; end
            ENC_OP_JR:      begin w_fmt = FMT_JR; w_fn = FN_JR;   end
            ENC_OP_SYSCALL: begin w_fmt = FMT_SYS; w_fn = FN_SYSCALL; end
            ENC_OP_ADD:     begin w_fmt = FMT_R3; w_fn = FN_ADD;  end
            ENC_OP_ADDU:    begin w_fmt = FMT_R3; w_fn = FN_ADDU; end
            ENC_OP_SUB:     begin w_fmt = FMT_R3; w_fn = FN_SUB;  end
            ENC_OP_SUBU:    begin w_fmt = FMT_R3; w_fn = FN_SUBU; end
            ENC_OP_AND:     begin w_fmt = FMT_R3; w_fn = FN_AND;  end
            ENC_OP_OR:      begin w_fmt = FMT_R3; w_fn = FN_OR;   end
            ENC_OP_XOR:     begin w_fmt = FMT_R3; w_fn = FN_XOR;  end
            ENC_OP_NOR:     begin w_fmt = FMT_R3; w_fn = FN_NOR;  end
            ENC_OP_SLT:     begin w_fmt = FMT_R3; w_fn = FN_SLT;  end
            ENC_OP_SLTU:    begin w_fmt = FMT_R3; w_fn = FN_SLTU; end
            ENC_OP_BLTZ:    begin w_fmt = FMT_BLTZ; w_opc = OPC_REGIMM; end
            ENC_OP_J:       begin w_fmt = FMT_J; w_opc = OPC_J;   end
            ENC_OP_JAL:     begin w_fmt = FMT_J; w_opc = OPC_JAL; end
            ENC_OP_BEQ:     begin w_fmt = FMT_I; w_opc = OPC_BEQ;   end
            ENC_OP_BNE:     begin w_fmt = FMT_I; w_opc = OPC_BNE;   end
            ENC_OP_ADDI:    begin w_fmt = FMT_I; w_opc = OPC_ADDI;  end
            ENC_OP_ADDIU:   begin w_fmt = FMT_I; w_opc = OPC_ADDIU; end
            ENC_OP_SLTI:    begin w_fmt = FMT_I; w_opc = OPC_SLTI;  end
            ENC_OP_SLTIU:   begin w_fmt = FMT_I; w_opc = OPC_SLTIU; end
            ENC_OP_ANDI:    begin w_fmt = FMT_I; w_opc = OPC_ANDI;  end
            ENC_OP_ORI:     begin w_fmt = FMT_I; w_opc = OPC_ORI;   end
            ENC_OP_XORI:    begin w_fmt = FMT_I; w_opc = OPC_XORI;  end
            ENC_OP_LUI:     begin w_fmt = FMT_LUI; w_opc = OPC_LUI; end
            ENC_OP_LB:      begin w_fmt = FMT_I; w_opc = OPC_LB;  end
            ENC_OP_LH:      begin w_fmt = FMT_I; w_opc = OPC_LH;  end
            ENC_OP_LW:      begin w_fmt = FMT_I; w_opc = OPC_LW;  end
            ENC_OP_LBU:     begin w_fmt = FMT_I; w_opc = OPC_LBU; end
            ENC_OP_LHU:     begin w_fmt = FMT_I; w_opc = OPC_LHU; end
            ENC_OP_SB:      begin w_fmt = FMT_I; w_opc = OPC_SB;  end
            ENC_OP_SH:      begin w_fmt = FMT_I; w_opc = OPC_SH;  end
            ENC_OP_SW:      begin w_fmt = FMT_I; w_opc = OPC_SW;  end
            default:        supported_o = 1'b0;
        endcase
    end

    // Assemble the word, keeping only the fields the layout owns.
    always_comb begin
        word_o = 32'h0000_0000;
        case (w_fmt)
            FMT_R3:   word_o = {OPC_SPECIAL, rs_i, rt_i, rd_i, 5'd0, w_fn};
            FMT_SH:   word_o = {OPC_SPECIAL, 5'd0, rt_i, rd_i, shamt_i, w_fn};
            FMT_JR:   word_o = {OPC_SPECIAL, rs_i, 15'd0, w_fn};
            FMT_SYS:  word_o = {26'd0, w_fn};
            FMT_I:    word_o = {w_opc, rs_i, rt_i, imm_i};
            FMT_LUI:  word_o = {w_opc, 5'd0, rt_i, imm_i};
            FMT_BLTZ: word_o = {OPC_REGIMM, rs_i, 5'd0, imm_i};
            FMT_J:    word_o = {w_opc, target_i};
            default:  word_o = 32'h0000_0000;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/inst_encoder.sv
// ============================================================================
// inst_encoder
// Accepts symbolic instruction requests over valid/ready, writes the packed
// words sequentially to instruction memory and appends an exit sequence on
// finish.
// Rev 1.0
// ============================================================================
`default_nettype none

module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int DEPTH     = 1024,
    parameter int BASE_ADDR = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [5:0]                   req_op,
    input  logic [4:0]                   req_rs,
    input  logic [4:0]                   req_rt,
    input  logic [4:0]                   req_rd,
    input  logic [4:0]                   req_shamt,
    input  logic [15:0]                  req_imm,
    input  logic [25:0]                  req_target,
    input  logic                         finish,
    output logic                         im_w_en,
    output logic [ADDR_W-1:0]            im_addr,
    output logic [31:0]                  im_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         done,
    output logic                         err_unsupported,
    output logic                         err_overflow
);

    localparam int CNT_W = $clog2(DEPTH+1);

    // The write pointer never wraps, so the window must fit the address space.
    if (BASE_ADDR + DEPTH > (1 << ADDR_W)) begin : g_addr_range_check
        $error("inst_encoder: BASE_ADDR + DEPTH exceeds 2**ADDR_W");
    end

    enc_state_e        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       data_q, data_d;
    logic              wen_q, wen_d;
    logic              unsup_q, unsup_d;
    logic              ovf_q, ovf_d;
    logic              fullv_q, fullv_d;   // valid was seen while full last cycle

    logic [31:0]       w_word;
    logic              w_supported;
    logic              w_space;
    logic              w_xfer;

    inst_field_packer u_packer (
        .op_i        (req_op),
        .rs_i        (req_rs),
        .rt_i        (req_rt),
        .rd_i        (req_rd),
        .shamt_i     (req_shamt),
        .imm_i       (req_imm),
        .target_i    (req_target),
        .word_o      (w_word),
        .supported_o (w_supported)
    );

    assign w_space         = (cnt_q < CNT_W'(DEPTH));
    assign req_ready       = (state_q == S_IDLE) && w_space;
    assign w_xfer          = req_valid && req_ready;

    assign im_w_en         = wen_q;
    assign im_addr         = addr_q;
    assign im_data         = data_q;
    assign count           = cnt_q;
    assign done            = (state_q == S_DONE);
    assign err_unsupported = unsup_q;
    assign err_overflow    = ovf_q;

    // Next-state: accept/encode requests, then emit the two exit words.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        wen_d   = 1'b0;
        unsup_d = unsup_q;
        ovf_d   = ovf_q;
        fullv_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                fullv_d = !w_space && req_valid;
                if (!w_space && req_valid && fullv_q) begin
                    ovf_d = 1'b1;
                end
                if (w_xfer) begin
                    if (w_supported) begin
                        wen_d  = 1'b1;
                        addr_d = ptr_q;
                        data_d = w_word;
                        ptr_d  = ptr_q + ADDR_W'(1);
                        cnt_d  = cnt_q + CNT_W'(1);
                    end else begin
                        unsup_d = 1'b1;
                    end
                end
                // Free-slot check includes a word accepted in this same cycle.
                if (finish) begin
                    if ((32'(DEPTH) - 32'(cnt_d)) >= 32'd2) begin
                        state_d = S_TERM0;
                    end else begin
                        ovf_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_TERM0: begin
                wen_d   = 1'b1;
                addr_d  = ptr_q;
                data_d  = ENC_EXIT_W0;
                ptr_d   = ptr_q + ADDR_W'(1);
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = S_TERM1;
            end
            S_TERM1: begin
                wen_d   = 1'b1;
                addr_d  = ptr_q;
                data_d  = ENC_EXIT_W1;
                ptr_d   = ptr_q + ADDR_W'(1);
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = S_DONE;
            end
            default: begin
                state_d = S_DONE;
            end
        endcase
    end

    // State and registered write-port outputs; reset aborts any load at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= ADDR_W'(BASE_ADDR);
            addr_q  <= '0;
            cnt_q   <= '0;
            data_q  <= 32'h0000_0000;
            wen_q   <= 1'b0;
            unsup_q <= 1'b0;
            ovf_q   <= 1'b0;
            fullv_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            wen_q   <= wen_d;
            unsup_q <= unsup_d;
            ovf_q   <= ovf_d;
            fullv_q <= fullv_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_inst_encoder.sv
// ============================================================================
// tb_inst_encoder
// Self-checking bench: two encoder instances (full size, and DEPTH=4 at
// BASE_ADDR=16) driven by directed and random requests, compared each cycle
// against a table-driven reference model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_inst_encoder;
    import inst_encoder_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n      [2];
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic [5:0]  req_op     [2];
    logic [4:0]  req_rs     [2];
    logic [4:0]  req_rt     [2];
    logic [4:0]  req_rd     [2];
    logic [4:0]  req_shamt  [2];
    logic [15:0] req_imm    [2];
    logic [25:0] req_target [2];
    logic        finish     [2];
    logic        im_w_en    [2];
    logic [9:0]  im_addr    [2];
    logic [31:0] im_data    [2];
    logic        done       [2];
    logic        err_unsup  [2];
    logic        err_ovf    [2];
    logic [10:0] count0;
    logic [2:0]  count1;

    inst_encoder #(.ADDR_W(10), .DEPTH(1024), .BASE_ADDR(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_op(req_op[0]), .req_rs(req_rs[0]), .req_rt(req_rt[0]), .req_rd(req_rd[0]),
        .req_shamt(req_shamt[0]), .req_imm(req_imm[0]), .req_target(req_target[0]),
        .finish(finish[0]), .im_w_en(im_w_en[0]), .im_addr(im_addr[0]), .im_data(im_data[0]),
        .count(count0), .done(done[0]), .err_unsupported(err_unsup[0]), .err_overflow(err_ovf[0])
    );

    inst_encoder #(.ADDR_W(10), .DEPTH(4), .BASE_ADDR(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_op(req_op[1]), .req_rs(req_rs[1]), .req_rt(req_rt[1]), .req_rd(req_rd[1]),
        .req_shamt(req_shamt[1]), .req_imm(req_imm[1]), .req_target(req_target[1]),
        .finish(finish[1]), .im_w_en(im_w_en[1]), .im_addr(im_addr[1]), .im_data(im_data[1]),
        .count(count1), .done(done[1]), .err_unsupported(err_unsup[1]), .err_overflow(err_ovf[1])
    );

    int total  = 0;
    int passed = 0;

    // Reference encoding table: template word plus mask of kept fields
    // mask bits: [5] rs, [4] rt, [3] rd, [2] shamt, [1] imm, [0] target
    logic [31:0] t_tmpl [64];
    logic [5:0]  t_mask [64];
    bit          t_ok   [64];

    // Reference model state per instance
    int          m_depth [2] = '{1024, 4};
    int          m_base  [2] = '{0, 16};
    int          m_cnt   [2];
    int          m_ptr   [2];
    int          m_pend  [2];   // exit words still to emit
    bit          m_done  [2];
    bit          m_unsup [2];
    bit          m_ovf   [2];
    bit          m_fullv [2];
    bit          e_wen   [2];
    logic [31:0] e_addr  [2];
    logic [31:0] e_data  [2];

    task automatic def(input logic [5:0] op, input logic [31:0] tmpl, input logic [5:0] mask);
        t_tmpl[op] = tmpl;
        t_mask[op] = mask;
        t_ok[op]   = 1'b1;
    endtask

    function automatic logic [31:0] ref_word(input int d);
        logic [31:0] w;
        int k;
        k = int'(req_op[d]);
        w = t_tmpl[k];
        if (t_mask[k][5]) w = w | (32'(req_rs[d]) << 21);
        if (t_mask[k][4]) w = w | (32'(req_rt[d]) << 16);
        if (t_mask[k][3]) w = w | (32'(req_rd[d]) << 11);
        if (t_mask[k][2]) w = w | (32'(req_shamt[d]) << 6);
        if (t_mask[k][1]) w = w | 32'(req_imm[d]);
        if (t_mask[k][0]) w = w | 32'(req_target[d]);
        return w;
    endfunction

    task automatic mreset(input int d);
        m_cnt[d] = 0; m_ptr[d] = m_base[d]; m_pend[d] = 0;
        m_done[d] = 0; m_unsup[d] = 0; m_ovf[d] = 0; m_fullv[d] = 0; e_wen[d] = 0;
    endtask

    // Advance the reference model by one clock edge using the current inputs.
    task automatic model(input int d);
        bit fv, rdy;
        fv = m_fullv[d];
        m_fullv[d] = 0;
        e_wen[d] = 0;
        if (m_done[d]) begin
            // load finished; nothing changes until reset
        end else if (m_pend[d] > 0) begin
            e_wen[d]  = 1;
            e_addr[d] = 32'(m_ptr[d]);
            e_data[d] = (m_pend[d] == 2) ? 32'h2002000A : 32'h0000000C;
            m_ptr[d]++; m_cnt[d]++; m_pend[d]--;
            if (m_pend[d] == 0) m_done[d] = 1;
        end else begin
            rdy = (m_cnt[d] < m_depth[d]);
            if (req_valid[d] && rdy) begin
                if (t_ok[int'(req_op[d])]) begin
                    e_wen[d]  = 1;
                    e_addr[d] = 32'(m_ptr[d]);
                    e_data[d] = ref_word(d);
                    m_ptr[d]++; m_cnt[d]++;
                end else begin
                    m_unsup[d] = 1;
                end
            end
            if (!rdy && req_valid[d] && fv) m_ovf[d] = 1;
            m_fullv[d] = !rdy && req_valid[d];
            if (finish[d]) begin
                if (m_depth[d] - m_cnt[d] >= 2) m_pend[d] = 2;
                else begin m_ovf[d] = 1; m_done[d] = 1; end
            end
        end
    endtask

    task automatic chk(input int d, input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL dut%0d %s: observed %h expected %h", d, tag, obs, exp);
    endtask

    function automatic logic [31:0] cnt_of(input int d);
        return (d == 0) ? 32'(count0) : 32'(count1);
    endfunction

    task automatic check_all(input int d);
        bit rdy;
        rdy = !m_done[d] && (m_pend[d] == 0) && (m_cnt[d] < m_depth[d]);
        chk(d, "req_ready", 32'(req_ready[d]), 32'(rdy));
        chk(d, "im_w_en", 32'(im_w_en[d]), 32'(e_wen[d]));
        if (e_wen[d]) begin
            chk(d, "im_addr", 32'(im_addr[d]), e_addr[d]);
            chk(d, "im_data", im_data[d], e_data[d]);
        end
        chk(d, "count", cnt_of(d), 32'(m_cnt[d]));
        chk(d, "done", 32'(done[d]), 32'(m_done[d]));
        chk(d, "err_unsupported", 32'(err_unsup[d]), 32'(m_unsup[d]));
        chk(d, "err_overflow", 32'(err_ovf[d]), 32'(m_ovf[d]));
    endtask

    task automatic reset_chk(input int d);
        chk(d, "rst_w_en", 32'(im_w_en[d]), 32'd0);
        chk(d, "rst_addr", 32'(im_addr[d]), 32'd0);
        chk(d, "rst_data", im_data[d], 32'd0);
        chk(d, "rst_count", cnt_of(d), 32'd0);
        chk(d, "rst_done", 32'(done[d]), 32'd0);
        chk(d, "rst_unsup", 32'(err_unsup[d]), 32'd0);
        chk(d, "rst_ovf", 32'(err_ovf[d]), 32'd0);
    endtask

    task automatic drv(input int d, input logic v, input logic [5:0] op,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [4:0] sh, input logic [15:0] imm, input logic [25:0] tgt,
                       input logic fin);
        req_valid[d] = v; req_op[d] = op; req_rs[d] = rs; req_rt[d] = rt; req_rd[d] = rd;
        req_shamt[d] = sh; req_imm[d] = imm; req_target[d] = tgt; finish[d] = fin;
    endtask

    task automatic idle(input int d);
        drv(d, 1'b0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        model(0);
        model(1);
        #1;
        check_all(0);
        check_all(1);
    endtask

    task automatic do_reset();
        idle(0); idle(1);
        rst_n[0] = 1'b0; rst_n[1] = 1'b0;
        #3;
        reset_chk(0); reset_chk(1);
        mreset(0); mreset(1);
        @(negedge clk);
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 64; k++) begin t_tmpl[k] = '0; t_mask[k] = '0; t_ok[k] = 0; end
        def(ENC_OP_SLL, 32'h00000000, 6'b011100); def(ENC_OP_SRL, 32'h00000002, 6'b011100);
        def(ENC_OP_SRA, 32'h00000003, 6'b011100); def(ENC_OP_SLLV, 32'h00000004, 6'b111000);
        def(ENC_OP_SRLV, 32'h00000006, 6'b111000); def(ENC_OP_SRAV, 32'h00000007, 6'b111000);
        def(ENC_OP_JR, 32'h00000008, 6'b100000); def(ENC_OP_SYSCALL, 32'h0000000C, 6'b000000);
        def(ENC_OP_ADD, 32'h00000020, 6'b111000); def(ENC_OP_ADDU, 32'h00000021, 6'b111000);
        def(ENC_OP_SUB, 32'h00000022, 6'b111000); def(ENC_OP_SUBU, 32'h00000023, 6'b111000);
        def(ENC_OP_AND, 32'h00000024, 6'b111000); def(ENC_OP_OR, 32'h00000025, 6'b111000);
        def(ENC_OP_XOR, 32'h00000026, 6'b111000); def(ENC_OP_NOR, 32'h00000027, 6'b111000);
        def(ENC_OP_SLT, 32'h0000002A, 6'b111000); def(ENC_OP_SLTU, 32'h0000002B, 6'b111000);
        def(ENC_OP_BLTZ, 32'h04000000, 6'b100010);
        def(ENC_OP_J, 32'h08000000, 6'b000001); def(ENC_OP_JAL, 32'h0C000000, 6'b000001);
        def(ENC_OP_BEQ, 32'h10000000, 6'b110010); def(ENC_OP_BNE, 32'h14000000, 6'b110010);
        def(ENC_OP_ADDI, 32'h20000000, 6'b110010); def(ENC_OP_ADDIU, 32'h24000000, 6'b110010);
        def(ENC_OP_SLTI, 32'h28000000, 6'b110010); def(ENC_OP_SLTIU, 32'h2C000000, 6'b110010);
        def(ENC_OP_ANDI, 32'h30000000, 6'b110010); def(ENC_OP_ORI, 32'h34000000, 6'b110010);
        def(ENC_OP_XORI, 32'h38000000, 6'b110010); def(ENC_OP_LUI, 32'h3C000000, 6'b010010);
        def(ENC_OP_LB, 32'h80000000, 6'b110010); def(ENC_OP_LH, 32'h84000000, 6'b110010);
        def(ENC_OP_LW, 32'h8C000000, 6'b110010); def(ENC_OP_LBU, 32'h90000000, 6'b110010);
        def(ENC_OP_LHU, 32'h94000000, 6'b110010); def(ENC_OP_SB, 32'hA0000000, 6'b110010);
        def(ENC_OP_SH, 32'hA4000000, 6'b110010); def(ENC_OP_SW, 32'hAC000000, 6'b110010);

        // Reset state
        do_reset();
        tick();

        // Single add: write lands the cycle after the transfer
        drv(0, 1, ENC_OP_ADD, 8, 9, 10, 0, 0, 0, 0);
        tick();
        idle(0);
        chk(0, "add_word", im_data[0], 32'h01095020);
        chk(0, "add_addr", 32'(im_addr[0]), 32'd0);
        chk(0, "add_count", cnt_of(0), 32'd1);
        tick();
        chk(0, "add_pulse_end", 32'(im_w_en[0]), 32'd0);

        // Back-to-back addi / lw / sll
        do_reset();
        drv(0, 1, ENC_OP_ADDI, 0, 8, 0, 0, 16'd5, 0, 0);
        tick();
        chk(0, "addi_word", im_data[0], 32'h20080005);
        drv(0, 1, ENC_OP_LW, 29, 9, 0, 0, 16'd4, 0, 0);
        tick();
        chk(0, "lw_word", im_data[0], 32'h8FA90004);
        chk(0, "lw_addr", 32'(im_addr[0]), 32'd1);
        drv(0, 1, ENC_OP_SLL, 7, 9, 8, 2, 0, 0, 0);   // rs must be dropped
        tick();
        chk(0, "sll_word", im_data[0], 32'h00094080);
        chk(0, "sll_strobe", 32'(im_w_en[0]), 32'd1);
        idle(0);
        tick();

        // j then finish: j word, exit pair, then done with ready held low
        do_reset();
        drv(0, 1, ENC_OP_J, 0, 0, 0, 0, 0, 26'h100, 0);
        tick();
        chk(0, "j_word", im_data[0], 32'h08000100);
        drv(0, 0, 6'd0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        idle(0);
        tick();
        chk(0, "exit_w0", im_data[0], 32'h2002000A);
        tick();
        chk(0, "exit_w1", im_data[0], 32'h0000000C);
        chk(0, "exit_w1_addr", 32'(im_addr[0]), 32'd2);
        drv(0, 1, ENC_OP_ADD, 1, 2, 3, 0, 0, 0, 1);   // ignored once done
        for (int i = 0; i < 3; i++) tick();
        chk(0, "done_held", 32'(done[0]), 32'd1);
        chk(0, "ready_held", 32'(req_ready[0]), 32'd0);

        // Request and finish in the same cycle: request word first
        do_reset();
        drv(0, 1, ENC_OP_ADDU, 3, 4, 5, 0, 0, 0, 1);
        tick();
        idle(0);
        for (int i = 0; i < 3; i++) tick();

        // Unsupported op: no write, sticky flag, next op at same address
        do_reset();
        drv(0, 1, 6'h3F, 1, 2, 3, 4, 16'h1234, 0, 0);
        tick();
        chk(0, "unsup_flag", 32'(err_unsup[0]), 32'd1);
        chk(0, "unsup_nowrite", 32'(im_w_en[0]), 32'd0);
        drv(0, 1, ENC_OP_OR, 1, 2, 3, 0, 0, 0, 0);
        tick();
        chk(0, "after_unsup_addr", 32'(im_addr[0]), 32'd0);
        chk(0, "unsup_sticky", 32'(err_unsup[0]), 32'd1);
        idle(0);
        tick();

        // DEPTH=4: fill, hold valid while full, then finish with no room
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drv(1, 1, ENC_OP_ADDI, 5'(i), 5'(i + 1), 0, 0, 16'(i * 3), 0, 0);
            tick();
        end
        chk(1, "full_ready", 32'(req_ready[1]), 32'd0);
        chk(1, "last_addr", 32'(im_addr[1]), 32'd19);
        tick();
        chk(1, "hold1_no_ovf", 32'(err_ovf[1]), 32'd0);
        tick();
        chk(1, "hold2_ovf", 32'(err_ovf[1]), 32'd1);
        drv(1, 0, 6'd0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        idle(1);
        chk(1, "full_finish_done", 32'(done[1]), 32'd1);
        tick();

        // DEPTH=4 with three words: exit pair does not fit
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drv(1, 1, ENC_OP_XORI, 5'(i), 5'(i), 0, 0, 16'hFFFF, 0, 0);
            tick();
        end
        drv(1, 0, 6'd0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        idle(1);
        chk(1, "three_finish_ovf", 32'(err_ovf[1]), 32'd1);
        chk(1, "three_finish_nowrite", 32'(im_w_en[1]), 32'd0);
        tick();

        // DEPTH=4 with two words: exit pair exactly fits
        do_reset();
        for (int i = 0; i < 2; i++) begin
            drv(1, 1, ENC_OP_LUI, 5'd31, 5'(i + 4), 0, 0, 16'hBEEF, 0, 0);
            tick();
        end
        drv(1, 0, 6'd0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        idle(1);
        for (int i = 0; i < 3; i++) tick();
        chk(1, "two_fit_ovf", 32'(err_ovf[1]), 32'd0);

        // Asynchronous reset while in S_TERM0
        do_reset();
        drv(0, 1, ENC_OP_J, 0, 0, 0, 0, 0, 26'h2ABCDEF, 0);
        tick();
        drv(0, 0, 6'd0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        idle(0);
        #2;
        rst_n[0] = 1'b0;
        #1;
        reset_chk(0);
        mreset(0);
        @(negedge clk);
        rst_n[0] = 1'b1;
        tick();
        drv(0, 1, ENC_OP_BLTZ, 6, 17, 0, 0, 16'hFFFE, 0, 0);
        tick();
        chk(0, "post_rst_addr", 32'(im_addr[0]), 32'd0);
        idle(0);

        // Random traffic on both instances against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            for (int d = 0; d < 2; d++) begin
                drv(d, ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 9) == 0) ? 6'($urandom_range(39, 63)) : 6'($urandom_range(0, 38)),
                    5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                    16'($urandom), 26'($urandom),
                    ($urandom_range(0, (d == 0) ? 299 : 29) == 0));
            end
            tick();
        end
        idle(0); idle(1);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
